flash_sample_reader: RTL and testbench

Downstream consumer of the keyboard address stage in the flash audio player. Takes the current 23-bit flash word address and play/pause/direction status from the keyboard address block, fetches the 32-bit word from flash over an Avalon-MM read master, and emits the two 16-bit audio samples it contains, one per sample-rate tick. After the second sample it pulses `word_done`, which the address block uses to step to its next address.

---
 rtl/flash_sample_reader.sv | 128 ++++++++++++
 tb/tb_flash_sample_reader.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_sample_reader.sv
// Fetches one 32-bit flash word over Avalon-MM and plays its two 16-bit halves, one per sample tick.
// Optional read watchdog: define FLASH_READ_TIMEOUT_EN to build it (limit TIMEOUT_CYCLES).
module flash_sample_reader #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [22:0] addr,
  input  logic        pause,
  input  logic        backward,
  input  logic        sample_tick,
  output logic        flash_read,
  output logic [22:0] flash_address,
  output logic [3:0]  flash_byteenable,
  input  logic        flash_waitrequest,
  input  logic [31:0] flash_readdata,
  input  logic        flash_readdatavalid,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        word_done,
  output logic        rd_err
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD0, S_HOLD1} state_t;

  state_t      state;
  logic [31:0] word;
  logic        tick_ok;
  logic        data_in;

  assign flash_byteenable = 4'b1111;
  assign tick_ok = sample_tick & ~pause;
  // Data can arrive on the acceptance edge itself or any later edge in S_WAIT.
  assign data_in = ((state == S_REQ) && !flash_waitrequest && flash_readdatavalid) ||
                   ((state == S_WAIT) && flash_readdatavalid);

`ifdef FLASH_READ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic          timeout;

  assign timeout = ((state == S_REQ) || (state == S_WAIT)) && !data_in &&
                   (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt   <= '0;
      rd_err <= 1'b0;
    end else begin
      if (((state == S_REQ) || (state == S_WAIT)) && !timeout)
        tcnt <= tcnt + 1'b1;
      else
        tcnt <= '0;
      if (timeout)
        rd_err <= 1'b1;
    end
  end
`else
  // Without the watchdog the flag can never rise; the limit is irrelevant.
  assign rd_err = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      flash_read    <= 1'b0;
      flash_address <= '0;
      word          <= '0;
      sample        <= '0;
      sample_valid  <= 1'b0;
      word_done     <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      word_done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!pause) begin
            flash_address <= addr;
            flash_read    <= 1'b1;
            state         <= S_REQ;
          end
        end
        S_REQ: begin
          if (!flash_waitrequest) begin
            flash_read <= 1'b0;
            if (flash_readdatavalid) begin
              word  <= flash_readdata;
              state <= S_HOLD0;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (flash_readdatavalid) begin
            word  <= flash_readdata;
            state <= S_HOLD0;
          end
        end
        S_HOLD0: begin
          if (tick_ok) begin
            sample       <= backward ? word[31:16] : word[15:0];
            sample_valid <= 1'b1;
            state        <= S_HOLD1;
          end
        end
        S_HOLD1: begin
          if (tick_ok) begin
            sample       <= backward ? word[15:0] : word[31:16];
            sample_valid <= 1'b1;
            word_done    <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
`ifdef FLASH_READ_TIMEOUT_EN
      // A dead flash plays silence instead of stalling the player.
      if (timeout) begin
        flash_read <= 1'b0;
        word       <= '0;
        state      <= S_HOLD0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_flash_sample_reader.sv
// Directed bench for flash_sample_reader: scripted Avalon flash responder, word-level playback model, literal checks.
module tb_flash_sample_reader;

  logic        clk;
  logic        reset_n;
  logic [22:0] addr;
  logic        pause;
  logic        backward;
  logic        sample_tick;
  logic        flash_read;
  logic [22:0] flash_address;
  logic [3:0]  flash_byteenable;
  logic        flash_waitrequest;
  logic [31:0] flash_readdata;
  logic        flash_readdatavalid;
  logic [15:0] sample;
  logic        sample_valid;
  logic        word_done;
  logic        rd_err;

  flash_sample_reader #(.TIMEOUT_CYCLES(256)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .addr                (addr),
    .pause               (pause),
    .backward            (backward),
    .sample_tick         (sample_tick),
    .flash_read          (flash_read),
    .flash_address       (flash_address),
    .flash_byteenable    (flash_byteenable),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdata      (flash_readdata),
    .flash_readdatavalid (flash_readdatavalid),
    .sample              (sample),
    .sample_valid        (sample_valid),
    .word_done           (word_done),
    .rd_err              (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Flash responder configuration
  logic [22:0] cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  int          cfg_wait = 0;
  int          cfg_lat  = 1;
  bit          cfg_never = 0;
  bit          force_late = 0;
  bit          resp_cap = 0;
  bit          to_cap = 0;
  int          ph = 0, wcnt = 0, lcnt = 0, tcnt = 0;

  always @(posedge clk) begin
    #1;
    flash_readdatavalid = 1'b0;
    resp_cap = 1'b0;
    to_cap = 1'b0;
    if (!reset_n) begin
      ph = 0; wcnt = 0; lcnt = 0; tcnt = 0;
      flash_waitrequest = 1'b1;
    end else begin
      if (ph != 0) tcnt++;
      if (ph == 0 && flash_read) begin
        chk("flash_address", 32'(flash_address), 32'(cfg_addr));
        ph = 1; wcnt = 0; tcnt = 0;
      end
      if (ph == 1) begin
        if (wcnt < cfg_wait) begin
          flash_waitrequest = 1'b1;
          wcnt++;
        end else begin
          flash_waitrequest = 1'b0;
          lcnt = 0;
          ph = 2;
          if (cfg_lat == 0 && !cfg_never) begin
            flash_readdatavalid = 1'b1;
            flash_readdata = cfg_data;
            resp_cap = 1'b1;
            ph = 0;
          end
        end
      end else if (ph == 2) begin
        flash_waitrequest = 1'b1;
        lcnt++;
        if (!cfg_never && lcnt == cfg_lat) begin
          flash_readdatavalid = 1'b1;
          flash_readdata = cfg_data;
          resp_cap = 1'b1;
          ph = 0;
        end
      end
`ifdef FLASH_READ_TIMEOUT_EN
      if (ph != 0 && cfg_never && tcnt == 255) begin
        to_cap = 1'b1;
        ph = 0;
        flash_waitrequest = 1'b1;
      end
`endif
      if (force_late) begin
        flash_readdatavalid = 1'b1;
        flash_readdata = 32'h1234_5678;
        force_late = 0;
      end
    end
  end

  // Playback model: a captured word yields two halves on the next two unpaused ticks.
  logic [31:0] mword = '0;
  int          halves = 0;
  int          cap_cnt = 0;
  logic [15:0] exp_sample = '0;
  logic        exp_sv = 1'b0;
  logic        exp_wd = 1'b0;
  logic        exp_rderr = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      halves = 0;
      exp_sample = '0;
      exp_sv = 1'b0;
      exp_wd = 1'b0;
      exp_rderr = 1'b0;
    end else begin
      exp_sv = 1'b0;
      exp_wd = 1'b0;
      if (halves > 0 && sample_tick && !pause) begin
        logic hi;
        hi = (halves == 2) ? backward : !backward;
        exp_sample = hi ? mword[31:16] : mword[15:0];
        exp_sv = 1'b1;
        exp_wd = (halves == 1);
        halves--;
      end
      if (flash_readdatavalid && resp_cap) begin
        mword = flash_readdata;
        halves = 2;
        cap_cnt++;
      end
      if (to_cap) begin
        mword = '0;
        halves = 2;
        exp_rderr = 1'b1;
        cap_cnt++;
      end
    end
  end

  bit          cmp_en = 0;
  logic [16:0] log_q[$];

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("sample", 32'(sample), 32'(exp_sample));
      chk("sample_valid", 32'(sample_valid), 32'(exp_sv));
      chk("word_done", 32'(word_done), 32'(exp_wd));
      chk("rd_err", 32'(rd_err), 32'(exp_rderr));
      if (sample_valid) log_q.push_back({word_done, sample});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
  endtask

  task automatic pop_chk(input string name, input logic [16:0] exp);
    if (log_q.size() == 0) chk(name, 32'h1_DEAD, 32'(exp));
    else chk(name, 32'(log_q.pop_front()), 32'(exp));
  endtask

  task automatic wait_cap(input int c0, input int budget);
    int n = 0;
    while (cap_cnt == c0 && n < budget) begin
      step(1);
      n++;
    end
    chk("fetch_done", 32'(cap_cnt != c0), 32'd1);
  endtask

  task automatic wait_read(input int budget);
    int n = 0;
    while (!flash_read && n < budget) begin
      step(1);
      n++;
    end
    chk("flash_read_rise", 32'(flash_read), 32'd1);
  endtask

  task automatic run_word(input string name, input logic [22:0] a, input logic [31:0] d,
                          input logic bwd, input int w, input int l,
                          input logic [15:0] s0, input logic [15:0] s1);
    int c0;
    cfg_addr = a; cfg_data = d; cfg_wait = w; cfg_lat = l;
    addr = a; backward = bwd;
    c0 = cap_cnt;
    pause = 1'b0;
    step(1);
    tick();
    wait_cap(c0, 100);
    step(1);
    tick();
    step(3);
    tick();
    pause = 1'b1;
    step(2);
    pop_chk({name, "_first"}, {1'b0, s0});
    pop_chk({name, "_second"}, {1'b1, s1});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset_n = 1'b0;
    addr = '0;
    pause = 1'b1;
    backward = 1'b0;
    sample_tick = 1'b0;
    flash_waitrequest = 1'b1;
    flash_readdata = '0;
    flash_readdatavalid = 1'b0;
    step(3);
    cmp_en = 1;
    chk("rst_flash_read", 32'(flash_read), 32'd0);
    chk("rst_flash_address", 32'(flash_address), 32'd0);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("byteenable", 32'(flash_byteenable), 32'hF);
    reset_n = 1'b1;
    step(3);

    run_word("fwd", 23'h000010, 32'hAAAA_5555, 1'b0, 3, 2, 16'h5555, 16'hAAAA);
    run_word("bwd", 23'h000010, 32'hAAAA_5555, 1'b1, 3, 2, 16'hAAAA, 16'h5555);
    run_word("same_edge", 23'h7FFFFF, 32'h1234_ABCD, 1'b0, 1, 0, 16'hABCD, 16'h1234);
    run_word("nowait_bwd", 23'h400000, 32'hFFFF_0001, 1'b1, 0, 1, 16'hFFFF, 16'h0001);

    // Pause raised during S_WAIT: read completes, paused ticks are ignored
    cfg_addr = 23'h000123; cfg_data = 32'hBEEF_0F0F; cfg_wait = 0; cfg_lat = 4;
    addr = 23'h000123; backward = 1'b0;
    c0 = cap_cnt;
    pause = 1'b0;
    wait_read(20);
    step(1);
    pause = 1'b1;
    wait_cap(c0, 50);
    for (int i = 0; i < 3; i++) begin
      tick();
      step(2);
    end
    chk("pause_no_samples", 32'(log_q.size()), 32'd0);
    pause = 1'b0;
    tick();
    step(1);
    pop_chk("pause_resume_first", {1'b0, 16'h0F0F});
    step(1);
    tick();
    pause = 1'b1;
    step(1);
    pop_chk("pause_resume_second", {1'b1, 16'hBEEF});

    // Reset mid-read
    cfg_addr = 23'h000055; cfg_data = 32'hCAFE_F00D; cfg_wait = 10; cfg_lat = 1;
    addr = 23'h000055;
    pause = 1'b0;
    wait_read(20);
    step(2);
    pause = 1'b1;
    chk("read_pending", 32'(flash_read), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_async_flash_read", 32'(flash_read), 32'd0);
    chk("rst_async_address", 32'(flash_address), 32'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    force_late = 1;
    step(4);
    chk("late_rdv_sample", 32'(sample), 32'd0);
    chk("late_rdv_idle", 32'(flash_read), 32'd0);
    chk("late_rdv_no_samples", 32'(log_q.size()), 32'd0);

`ifdef FLASH_READ_TIMEOUT_EN
    begin
      int n = 0;
      cfg_addr = 23'h000077; cfg_wait = 2; cfg_never = 1;
      addr = 23'h000077; backward = 1'b0;
      pause = 1'b0;
      wait_read(20);
      while (!rd_err && n < 400) begin
        step(1);
        n++;
      end
      chk("timeout_clocks", 32'(n), 32'd256);
      chk("timeout_read_low", 32'(flash_read), 32'd0);
      tick();
      step(2);
      tick();
      pause = 1'b1;
      step(2);
      pop_chk("timeout_first", {1'b0, 16'h0000});
      pop_chk("timeout_second", {1'b1, 16'h0000});
      chk("timeout_sticky", 32'(rd_err), 32'd1);
      cfg_never = 0;
    end
`endif

    step(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
